// File: rtl/ir_prefetch_pkg.sv
// Shared definitions for the prefetching instruction register: default widths,
// the per-cycle IR action encoding and a small parameter sanity helper.
package ir_prefetch_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_ARG_W  = 4;
    localparam int DEF_DEPTH  = 4;

    // What the IR register does on the coming edge, decided once per cycle
    typedef enum logic [2:0] {
        IR_HOLD,
        IR_FLUSH,
        IR_LOAD_HEAD,
        IR_BYPASS,
        IR_DRAIN
    } ir_action_e;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Prefetch queue: storage array with separate occupancy count so full and
// empty stay unambiguous while the pointers wrap naturally.
module ir_fifo
    import ir_prefetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("ir_fifo: DEPTH must be a power of two >= 2");
    end

    // Storage carries no reset; only pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/ir_prefetch.sv
// Instruction register fed by a prefetch queue, with an empty-queue bypass,
// branch flush and a sticky overflow flag; splits the IR into opcode/operand.
module ir_prefetch
    import ir_prefetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int ARG_W  = DEF_ARG_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              li_bar,
    input  logic              nxt,
    input  logic              flush,
    output logic [OP_W-1:0]   y_1,
    output logic [ARG_W-1:0]  y_2,
    output logic              valid,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    if (DATA_W != OP_W + ARG_W) begin : g_bad_width
        $error("ir_prefetch: DATA_W must equal OP_W + ARG_W");
    end

    ir_action_e        action;
    logic              push_req;
    logic              fifo_push;
    logic              fifo_pop;
    logic              ovf_set;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] ir_q;

    // Flush beats everything; an empty queue with a load pending feeds the IR directly
    always_comb begin
        action    = IR_HOLD;
        push_req  = 1'b0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        ovf_set   = 1'b0;
        if (flush) begin
            action = IR_FLUSH;
        end else if (nxt) begin
            if (!empty) begin
                action = IR_LOAD_HEAD;
            end else if (!li_bar) begin
                action = IR_BYPASS;
            end else begin
                action = IR_DRAIN;
            end
        end
        push_req  = !li_bar && !flush && (action != IR_BYPASS);
        fifo_pop  = (action == IR_LOAD_HEAD);
        fifo_push = push_req && (!full || fifo_pop);
        ovf_set   = push_req && full && !fifo_pop;
    end

    ir_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .flush   (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (d_in),
        .rd_data (fifo_head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ir_q  <= '0;
            valid <= 1'b0;
        end else begin
            case (action)
                IR_LOAD_HEAD: begin
                    ir_q  <= fifo_head;
                    valid <= 1'b1;
                end
                IR_BYPASS: begin
                    ir_q  <= d_in;
                    valid <= 1'b1;
                end
                IR_FLUSH, IR_DRAIN: begin
                    valid <= 1'b0;
                end
                default: begin
                    valid <= valid;
                end
            endcase
        end
    end

    // Sticky until reset so software can see that a fetch was ever lost
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    assign y_1 = ir_q[DATA_W-1 -: OP_W];
    assign y_2 = ir_q[ARG_W-1:0];

endmodule
